// File: rtl/exe_stage.sv
// Execute stage: Val2 generation, ALU, branch target, NZCV status register and EX/MEM register.
// Optional macro FORWARDING_EN adds Rn/Rm source selection from MEM/WB forwarding paths.
module exe_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        WB_EN_IN,
    input  logic        MEM_R_EN_IN,
    input  logic        MEM_W_EN_IN,
    input  logic        B_IN,
    input  logic        S_IN,
    input  logic [3:0]  EXE_CMD,
    input  logic [31:0] PC_IN,
    input  logic [31:0] Val_Rn,
    input  logic [31:0] Val_Rm,
    input  logic        imm,
    input  logic [11:0] Shift_operand,
    input  logic [23:0] Signed_imm_24,
    input  logic [3:0]  Dest_IN,
`ifdef FORWARDING_EN
    input  logic [1:0]  Sel_src1,
    input  logic [1:0]  Sel_src2,
    input  logic [31:0] MEM_fwd_val,
    input  logic [31:0] WB_fwd_val,
`endif
    output logic [3:0]  SR,
    output logic        Branch_taken,
    output logic [31:0] Branch_Address,
    output logic        WB_EN,
    output logic        MEM_R_EN,
    output logic        MEM_W_EN,
    output logic [31:0] ALU_Res,
    output logic [31:0] Val_Rm_out,
    output logic [3:0]  Dest
);

    function automatic logic [31:0] rotr(input logic [31:0] v, input logic [4:0] amt);
        return (v >> amt) | (v << (6'd32 - {1'b0, amt}));
    endfunction

    function automatic logic [31:0] asr(input logic [31:0] v, input logic [4:0] amt);
        logic signed [31:0] vs;
        vs = v;
        return vs >>> amt;
    endfunction

    logic [31:0] rn_p0, rm_p0, val2_p0, res_p0;
    logic [32:0] sum_p0;
    logic [3:0]  nzcv_p0;
    logic [3:0]  sr_p1;
    logic        c_p0, v_p0, known_p0, cin_p0;

`ifdef FORWARDING_EN
    always_comb begin
        case (Sel_src1)
            2'b01:   rn_p0 = MEM_fwd_val;
            2'b10:   rn_p0 = WB_fwd_val;
            default: rn_p0 = Val_Rn;
        endcase
        case (Sel_src2)
            2'b01:   rm_p0 = MEM_fwd_val;
            2'b10:   rm_p0 = WB_fwd_val;
            default: rm_p0 = Val_Rm;
        endcase
    end
`else
    assign rn_p0 = Val_Rn;
    assign rm_p0 = Val_Rm;
`endif

    // Memory offsets take priority over the immediate flag
    always_comb begin
        val2_p0 = rm_p0;
        if (MEM_R_EN_IN || MEM_W_EN_IN)
            val2_p0 = {20'b0, Shift_operand};
        else if (imm)
            val2_p0 = rotr({24'b0, Shift_operand[7:0]}, {Shift_operand[11:8], 1'b0});
        else begin
            case (Shift_operand[6:5])
                2'b00: val2_p0 = rm_p0 << Shift_operand[11:7];
                2'b01: val2_p0 = rm_p0 >> Shift_operand[11:7];
                2'b10: val2_p0 = asr(rm_p0, Shift_operand[11:7]);
                2'b11: val2_p0 = rotr(rm_p0, Shift_operand[11:7]);
            endcase
        end
    end

    // Carry-in is the registered C, never the flag being computed this cycle
    assign cin_p0 = sr_p1[1];

    always_comb begin
        res_p0   = 32'd0;
        sum_p0   = 33'd0;
        c_p0     = sr_p1[1];
        v_p0     = sr_p1[0];
        known_p0 = 1'b1;
        case (EXE_CMD)
            4'b0001: res_p0 = val2_p0;
            4'b1001: res_p0 = ~val2_p0;
            4'b0010, 4'b0011: begin
                sum_p0 = {1'b0, rn_p0} + {1'b0, val2_p0} + {32'd0, (EXE_CMD[0] & cin_p0)};
                res_p0 = sum_p0[31:0];
                c_p0   = sum_p0[32];
                v_p0   = (rn_p0[31] == val2_p0[31]) && (res_p0[31] != rn_p0[31]);
            end
            4'b0100, 4'b0101: begin
                sum_p0 = {1'b0, rn_p0} + {1'b0, ~val2_p0} + {32'd0, (EXE_CMD[0] ? cin_p0 : 1'b1)};
                res_p0 = sum_p0[31:0];
                c_p0   = sum_p0[32];
                v_p0   = (rn_p0[31] != val2_p0[31]) && (res_p0[31] != rn_p0[31]);
            end
            4'b0110: res_p0 = rn_p0 & val2_p0;
            4'b0111: res_p0 = rn_p0 | val2_p0;
            4'b1000: res_p0 = rn_p0 ^ val2_p0;
            default: known_p0 = 1'b0;
        endcase
        nzcv_p0 = known_p0 ? {res_p0[31], ~|res_p0, c_p0, v_p0} : sr_p1;
    end

    assign Branch_taken   = B_IN;
    assign Branch_Address = PC_IN + {{6{Signed_imm_24[23]}}, Signed_imm_24, 2'b00};

    // ---- EX/MEM boundary ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_p1      <= 4'd0;
            WB_EN      <= 1'b0;
            MEM_R_EN   <= 1'b0;
            MEM_W_EN   <= 1'b0;
            ALU_Res    <= 32'd0;
            Val_Rm_out <= 32'd0;
            Dest       <= 4'd0;
        end else if (!freeze) begin
            if (S_IN)
                sr_p1 <= nzcv_p0;
            WB_EN      <= WB_EN_IN;
            MEM_R_EN   <= MEM_R_EN_IN;
            MEM_W_EN   <= MEM_W_EN_IN;
            ALU_Res    <= res_p0;
            Val_Rm_out <= rm_p0;
            Dest       <= Dest_IN;
        end
    end

    assign SR = sr_p1;

endmodule

// File: tb/tb_exe_stage.sv
// Directed table-driven bench for exe_stage; FORWARDING_EN enables the forwarding vectors.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst, freeze, WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN, imm;
    logic [3:0]  EXE_CMD, Dest_IN;
    logic [31:0] PC_IN, Val_Rn, Val_Rm;
    logic [11:0] Shift_operand;
    logic [23:0] Signed_imm_24;
    logic [3:0]  SR, Dest;
    logic        Branch_taken, WB_EN, MEM_R_EN, MEM_W_EN;
    logic [31:0] Branch_Address, ALU_Res, Val_Rm_out;
`ifdef FORWARDING_EN
    logic [1:0]  Sel_src1, Sel_src2;
    logic [31:0] MEM_fwd_val, WB_fwd_val;
`endif

    int total = 0;
    int bad   = 0;

    exe_stage dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .WB_EN_IN(WB_EN_IN), .MEM_R_EN_IN(MEM_R_EN_IN), .MEM_W_EN_IN(MEM_W_EN_IN),
        .B_IN(B_IN), .S_IN(S_IN), .EXE_CMD(EXE_CMD), .PC_IN(PC_IN),
        .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .imm(imm), .Shift_operand(Shift_operand),
        .Signed_imm_24(Signed_imm_24), .Dest_IN(Dest_IN),
`ifdef FORWARDING_EN
        .Sel_src1(Sel_src1), .Sel_src2(Sel_src2),
        .MEM_fwd_val(MEM_fwd_val), .WB_fwd_val(WB_fwd_val),
`endif
        .SR(SR), .Branch_taken(Branch_taken), .Branch_Address(Branch_Address),
        .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .ALU_Res(ALU_Res), .Val_Rm_out(Val_Rm_out), .Dest(Dest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cmd;
        logic        s, wb, mr, mw, im;
        logic [11:0] so;
        logic [31:0] rn, rm;
        logic [3:0]  dst;
        logic [31:0] eres;
        logic [3:0]  esr;
    } vec_t;

    vec_t vecs[25];

    function automatic vec_t mk(input logic [3:0] cmd, input logic s, input logic wb,
                                input logic mr, input logic mw, input logic im,
                                input logic [11:0] so, input logic [31:0] rn,
                                input logic [31:0] rm, input logic [3:0] dst,
                                input logic [31:0] eres, input logic [3:0] esr);
        vec_t v;
        v.cmd = cmd; v.s = s; v.wb = wb; v.mr = mr; v.mw = mw; v.im = im;
        v.so = so; v.rn = rn; v.rm = rm; v.dst = dst; v.eres = eres; v.esr = esr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        EXE_CMD = v.cmd; S_IN = v.s; WB_EN_IN = v.wb; MEM_R_EN_IN = v.mr;
        MEM_W_EN_IN = v.mw; imm = v.im; Shift_operand = v.so;
        Val_Rn = v.rn; Val_Rm = v.rm; Dest_IN = v.dst;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_sr"}, {28'd0, SR}, 32'd0);
        chk({tag, "_res"}, ALU_Res, 32'd0);
        chk({tag, "_rmout"}, Val_Rm_out, 32'd0);
        chk({tag, "_ctl"}, {29'd0, WB_EN, MEM_R_EN, MEM_W_EN}, 32'd0);
        chk({tag, "_dest"}, {28'd0, Dest}, 32'd0);
    endtask

    initial begin
        vecs[0]  = mk(4'b0010, 0, 1, 0, 0, 1, 12'h003, 32'd5,        32'd0,        4'd3, 32'd8,        4'b0000);
        vecs[1]  = mk(4'b0100, 1, 0, 0, 0, 1, 12'h003, 32'd3,        32'd0,        4'd1, 32'd0,        4'b0110);
        vecs[2]  = mk(4'b0010, 1, 1, 0, 0, 1, 12'h001, 32'h7FFFFFFF, 32'd0,        4'd2, 32'h80000000, 4'b1001);
        vecs[3]  = mk(4'b0001, 0, 1, 0, 0, 0, 12'h240, 32'd0,        32'h80000000, 4'd4, 32'hF8000000, 4'b1001);
        vecs[4]  = mk(4'b0001, 0, 1, 0, 0, 0, 12'h460, 32'd0,        32'h000000FF, 4'd5, 32'hFF000000, 4'b1001);
        vecs[5]  = mk(4'b0001, 0, 1, 0, 0, 1, 12'h4FF, 32'd0,        32'd0,        4'd6, 32'hFF000000, 4'b1001);
        vecs[6]  = mk(4'b1001, 0, 1, 0, 0, 1, 12'h000, 32'd0,        32'd0,        4'd7, 32'hFFFFFFFF, 4'b1001);
        vecs[7]  = mk(4'b0100, 1, 1, 0, 0, 1, 12'h001, 32'd5,        32'd0,        4'd8, 32'd4,        4'b0010);
        vecs[8]  = mk(4'b0011, 0, 1, 0, 0, 1, 12'h001, 32'd1,        32'd0,        4'd9, 32'd3,        4'b0010);
        vecs[9]  = mk(4'b0101, 1, 1, 0, 0, 1, 12'h002, 32'd5,        32'd0,        4'd10, 32'd3,       4'b0010);
        vecs[10] = mk(4'b0100, 1, 1, 0, 0, 1, 12'h001, 32'd0,        32'd0,        4'd11, 32'hFFFFFFFF, 4'b1000);
        vecs[11] = mk(4'b0101, 0, 1, 0, 0, 1, 12'h002, 32'd5,        32'd0,        4'd12, 32'd2,       4'b1000);
        vecs[12] = mk(4'b0011, 0, 1, 0, 0, 1, 12'h001, 32'd1,        32'd0,        4'd13, 32'd2,       4'b1000);
        vecs[13] = mk(4'b0010, 0, 0, 0, 1, 1, 12'h804, 32'h100,      32'hDEAD,     4'd14, 32'h904,     4'b1000);
        vecs[14] = mk(4'b0010, 0, 1, 1, 0, 0, 12'h0FF, 32'h10,       32'h55,       4'd15, 32'h10F,     4'b1000);
        vecs[15] = mk(4'b0110, 1, 1, 0, 0, 0, 12'h000, 32'hFF00,     32'hF0F0,     4'd1, 32'hF000,     4'b0000);
        vecs[16] = mk(4'b0111, 0, 1, 0, 0, 0, 12'h000, 32'h0F,       32'hF0,       4'd2, 32'hFF,       4'b0000);
        vecs[17] = mk(4'b1000, 0, 1, 0, 0, 0, 12'h000, 32'hFF,       32'h0F,       4'd3, 32'hF0,       4'b0000);
        vecs[18] = mk(4'b0001, 0, 1, 0, 0, 0, 12'h220, 32'd0,        32'h80000000, 4'd4, 32'h08000000, 4'b0000);
        vecs[19] = mk(4'b0001, 1, 1, 0, 0, 0, 12'h080, 32'd0,        32'h40000000, 4'd5, 32'h80000000, 4'b1000);
        vecs[20] = mk(4'b0000, 1, 1, 0, 0, 0, 12'h000, 32'd7,        32'd7,        4'd6, 32'd0,        4'b1000);
        vecs[21] = mk(4'b0010, 1, 1, 0, 0, 1, 12'h001, 32'hFFFFFFFF, 32'd0,        4'd7, 32'd0,        4'b0110);
        vecs[22] = mk(4'b0001, 0, 1, 0, 0, 0, 12'h060, 32'd0,        32'h12345678, 4'd8, 32'h12345678, 4'b0110);
        vecs[23] = mk(4'b0010, 1, 1, 0, 0, 1, 12'h102, 32'h80000000, 32'd0,        4'd9, 32'd0,        4'b0111);
        vecs[24] = mk(4'b0100, 1, 1, 0, 0, 1, 12'h001, 32'h80000000, 32'd0,        4'd10, 32'h7FFFFFFF, 4'b0011);

        rst = 1'b0; freeze = 1'b0; B_IN = 1'b0; PC_IN = 32'd0; Signed_imm_24 = 24'd0;
`ifdef FORWARDING_EN
        Sel_src1 = 2'b00; Sel_src2 = 2'b00; MEM_fwd_val = 32'd0; WB_fwd_val = 32'd0;
`endif
        drive(vecs[0]);
        #12;
        chk_zero("reset");
        #10;
        rst = 1'b1;

        for (int i = 0; i < 25; i++) begin
            drive(vecs[i]);
            step();
            chk($sformatf("v%0d_res", i), ALU_Res, vecs[i].eres);
            chk($sformatf("v%0d_sr", i), {28'd0, SR}, {28'd0, vecs[i].esr});
            chk($sformatf("v%0d_ctl", i), {29'd0, WB_EN, MEM_R_EN, MEM_W_EN},
                {29'd0, vecs[i].wb, vecs[i].mr, vecs[i].mw});
            chk($sformatf("v%0d_dest", i), {28'd0, Dest}, {28'd0, vecs[i].dst});
            chk($sformatf("v%0d_rmout", i), Val_Rm_out, vecs[i].rm);
        end

        // freeze holds outputs and SR even with S set
        drive(mk(4'b0010, 1, 1, 0, 0, 1, 12'h001, 32'd1, 32'hAA, 4'd5, 32'd2, 4'b0000));
        step();
        chk("pre_frz_res", ALU_Res, 32'd2);
        chk("pre_frz_sr", {28'd0, SR}, 32'd0);
        freeze = 1'b1;
        drive(mk(4'b0100, 1, 0, 0, 0, 1, 12'h001, 32'd0, 32'hBB, 4'd9, 32'd0, 4'b0000));
        step();
        step();
        chk("frz_res", ALU_Res, 32'd2);
        chk("frz_sr", {28'd0, SR}, 32'd0);
        chk("frz_wb", {31'd0, WB_EN}, 32'd1);
        chk("frz_dest", {28'd0, Dest}, 32'd5);
        chk("frz_rmout", Val_Rm_out, 32'hAA);
        freeze = 1'b0;
        step();
        chk("unfrz_res", ALU_Res, 32'hFFFFFFFF);
        chk("unfrz_sr", {28'd0, SR}, 32'b1000);
        chk("unfrz_dest", {28'd0, Dest}, 32'd9);

        // asynchronous reset mid-cycle, then first edge after release captures inputs
        #2;
        rst = 1'b0;
        #1;
        chk_zero("async_rst");
        drive(mk(4'b0010, 1, 1, 0, 0, 1, 12'h003, 32'd5, 32'd0, 4'd3, 32'd8, 4'b0000));
        step();
        chk_zero("rst_hold");
        #2;
        rst = 1'b1;
        step();
        chk("post_rst_res", ALU_Res, 32'd8);
        chk("post_rst_wb", {31'd0, WB_EN}, 32'd1);

        // combinational branch outputs
        B_IN = 1'b1; PC_IN = 32'h20; Signed_imm_24 = 24'hFFFFFE;
        #1;
        chk("br_taken", {31'd0, Branch_taken}, 32'd1);
        chk("br_addr_back", Branch_Address, 32'h18);
        B_IN = 1'b0; PC_IN = 32'h100; Signed_imm_24 = 24'h000004;
        #1;
        chk("br_not_taken", {31'd0, Branch_taken}, 32'd0);
        chk("br_addr_fwd", Branch_Address, 32'h110);

`ifdef FORWARDING_EN
        Sel_src1 = 2'b01; MEM_fwd_val = 32'd10;
        drive(mk(4'b0010, 0, 1, 0, 0, 1, 12'h001, 32'd99, 32'd0, 4'd1, 32'd11, 4'b0000));
        step();
        chk("fwd_mem_rn", ALU_Res, 32'd11);
        Sel_src1 = 2'b11; Sel_src2 = 2'b10; WB_fwd_val = 32'hCAFE;
        drive(mk(4'b0010, 0, 0, 0, 1, 0, 12'h004, 32'h100, 32'h1234, 4'd2, 32'h104, 4'b0000));
        step();
        chk("fwd_sel11_rn", ALU_Res, 32'h104);
        chk("fwd_wb_store", Val_Rm_out, 32'hCAFE);
        Sel_src1 = 2'b00; Sel_src2 = 2'b01; MEM_fwd_val = 32'h80000000;
        drive(mk(4'b0001, 0, 1, 0, 0, 0, 12'h240, 32'd0, 32'd0, 4'd3, 32'hF8000000, 4'b0000));
        step();
        chk("fwd_mem_shift", ALU_Res, 32'hF8000000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
